traffic_fsm: RTL and testbench

Phase controller for a main-road / side-road intersection. It drives the shared interval timer through `start_timer`/`value`, waits on `expired`, and sequences the lamp outputs. It sits between the sensor and walk-button synchronizers and the lamp drivers. It is the initiator for the `timer` block, which is the responder.

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/traffic_fsm_walk_latch.sv | 26 ++
 rtl/traffic_fsm.sv | 132 +++++++++++++
 tb/tb_traffic_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection phase controller.
//   state_t        - phase encoding (3 bits, MG..WALK)
//   RED/YEL/GRN    - one-hot lamp codes, {red,yellow,green}
//   T_*_DEF        - default interval codes
//   lamps_of()     - {main,side} lamp pattern for a phase
package traffic_pkg;

  typedef enum logic [2:0] {
    MG   = 3'd0,
    MGX  = 3'd1,
    MY   = 3'd2,
    SG   = 3'd3,
    SGX  = 3'd4,
    SY   = 3'd5,
    WALK = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;
  localparam logic [3:0] T_WALK_DEF = 4'd5;

  // Returns {main_lights, side_lights}; anything unknown shows all-red.
  function automatic logic [5:0] lamps_of(input state_t s);
    logic [5:0] l;
    l = {RED, RED};
    case (s)
      MG, MGX: l = {GRN, RED};
      MY:      l = {YEL, RED};
      SG, SGX: l = {RED, GRN};
      SY:      l = {RED, YEL};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_fsm_walk_latch.sv
// walk_latch: remembers a pedestrian request until the WALK phase is entered.
//   clk1    - system clock
//   reset_n - asynchronous active-low reset
//   set     - request pulse (walk_req)
//   clr     - WALK entry this edge; wins over set, since a request seen in
//             the entry cycle is served by that same WALK phase
//   pend    - request pending
module walk_latch (
  input  logic clk1,
  input  logic reset_n,
  input  logic set,
  input  logic clr,
  output logic pend
);

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (set) begin
      pend <= 1'b1;
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// traffic_fsm: main-road / side-road phase controller. Starts the external
// interval timer on every phase entry and advances on a qualified expiry.
// Optional pedestrian phase is built when TRAFFIC_WALK_EN is defined.
//   clk1        - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   sensor      - side-road vehicle present (sampled on expiry only)
//   walk_req    - pedestrian request pulse
//   expired     - timer done level
//   start_timer - one-cycle timer load pulse
//   value       - interval code, held until the next phase entry
//   main_lights - {red,yellow,green} main road
//   side_lights - {red,yellow,green} side road
//   walk_lamp   - pedestrian lamp
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter logic [3:0] T_BASE = T_BASE_DEF,
  parameter logic [3:0] T_EXT  = T_EXT_DEF,
  parameter logic [3:0] T_YEL  = T_YEL_DEF,
  parameter logic [3:0] T_WALK = T_WALK_DEF
) (
  input  logic       clk1,
  input  logic       reset_n,
  input  logic       sensor,
  input  logic       walk_req,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] value,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp
);

  state_t     state, state_n;
  logic       start_n;
  logic [3:0] value_n;
  logic       arm;
  logic       start_d;
  logic       qual;
  logic       pend_eff;

  function automatic logic [3:0] code_of(input state_t s);
    logic [3:0] c;
    c = T_BASE;
    case (s)
      MG, SG:  c = T_BASE;
      MGX, SGX: c = T_EXT;
      MY, SY:  c = T_YEL;
      WALK:    c = T_WALK;
      default: c = T_BASE;
    endcase
    return c;
  endfunction

  // Blank the start cycle and the one after it so a stale expired level
  // from the previous interval cannot advance the phase.
  assign qual = expired && !arm && !start_timer && !start_d;

`ifdef TRAFFIC_WALK_EN
  logic walk_pend;
  logic enter_walk;

  assign enter_walk = qual && (state_n == WALK);
  // A request in the same cycle as the MY expiry still counts.
  assign pend_eff   = walk_pend | walk_req;

  walk_latch u_walk_latch (
    .clk1    (clk1),
    .reset_n (reset_n),
    .set     (walk_req),
    .clr     (enter_walk),
    .pend    (walk_pend)
  );

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      walk_lamp <= 1'b0;
    end else begin
      walk_lamp <= (state_n == WALK);
    end
  end
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
  assign pend_eff        = 1'b0;
  assign walk_lamp       = 1'b0;
`endif

  always_comb begin
    state_n = state;
    start_n = 1'b0;
    value_n = value;
    if (arm) begin
      // First edge after reset launches the MG interval.
      state_n = MG;
      start_n = 1'b1;
      value_n = T_BASE;
    end else if (qual) begin
      case (state)
        MG, MGX: state_n = sensor ? MY : MGX;
        MY:      state_n = pend_eff ? WALK : SG;
        WALK:    state_n = SG;
        SG:      state_n = sensor ? SGX : SY;
        SGX:     state_n = SY;
        SY:      state_n = MG;
        default: state_n = MG;
      endcase
      start_n = 1'b1;
      value_n = code_of(state_n);
    end
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= MG;
      start_timer <= 1'b0;
      value       <= T_BASE;
      main_lights <= GRN;
      side_lights <= RED;
      arm         <= 1'b1;
      start_d     <= 1'b0;
    end else begin
      state                      <= state_n;
      start_timer                <= start_n;
      value                      <= value_n;
      {main_lights, side_lights} <= lamps_of(state_n);
      arm                        <= 1'b0;
      start_d                    <= start_timer;
    end
  end

endmodule

// File: tb/tb_traffic_fsm.sv
module tb_traffic_fsm;

  logic       clk1 = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_req = 1'b0;
  logic       expired;
  logic       start_timer;
  logic [3:0] value;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;

  int tests = 0;
  int fails = 0;

  logic force_exp = 1'b0;
  logic tm_exp = 1'b0;
  int   cnt = 0;

  always #5 clk1 = ~clk1;

  // Timer model: expired rises value cycles after a start, falls on next start.
  always @(posedge clk1) begin
    if (start_timer) begin
      cnt    <= int'(value);
      tm_exp <= 1'b0;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt    <= 0;
      tm_exp <= 1'b1;
    end
  end

  assign expired = force_exp | tm_exp;

  traffic_fsm dut (
    .clk1        (clk1),
    .reset_n     (reset_n),
    .sensor      (sensor),
    .walk_req    (walk_req),
    .expired     (expired),
    .start_timer (start_timer),
    .value       (value),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .walk_lamp   (walk_lamp)
  );

  // Advance to the next negedge on which start_timer is high (bounded).
  task automatic wait_start(input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk1);
      if (start_timer) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic ok;
    reset_n = 1'b0;
    sensor  = 1'b0;
    repeat (2) @(negedge clk1);
    tests++;
    if (main_lights !== 3'b001 || side_lights !== 3'b100 || walk_lamp !== 1'b0 ||
        start_timer !== 1'b0 || value !== 4'd6) begin
      fails++;
      $display("FAIL reset: main=%b side=%b walk=%b start=%b value=%0d, want 001 100 0 0 6",
               main_lights, side_lights, walk_lamp, start_timer, value);
    end
    reset_n = 1'b1;
    @(negedge clk1);
    tests++;
    if (start_timer !== 1'b1 || value !== 4'd6 || main_lights !== 3'b001) begin
      fails++;
      $display("FAIL first_start: start=%b value=%0d main=%b, want 1 6 001",
               start_timer, value, main_lights);
    end
    @(negedge clk1);
    tests++;
    if (start_timer !== 1'b0) begin
      fails++;
      $display("FAIL first_start_width: start=%b, want 0", start_timer);
    end
    // No side car: MGX re-entered repeatedly with the extension code.
    for (int i = 0; i < 3; i++) begin
      wait_start(40, ok);
      tests++;
      if (!ok || value !== 4'd3 || main_lights !== 3'b001 || side_lights !== 3'b100) begin
        fails++;
        $display("FAIL mgx[%0d]: ok=%b value=%0d main=%b side=%b, want 1 3 001 100",
                 i, ok, value, main_lights, side_lights);
      end
    end
  endtask

  task automatic test_sensor_cycle;
    logic       ok;
    logic [3:0] ev[5] = '{4'd2, 4'd6, 4'd3, 4'd2, 4'd6};
    logic [2:0] em[5] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [2:0] es[5] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b100};
    sensor = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_start(40, ok);
      tests++;
      if (!ok || value !== ev[i] || main_lights !== em[i] || side_lights !== es[i]) begin
        fails++;
        $display("FAIL cycle[%0d]: ok=%b value=%0d main=%b side=%b, want value=%0d main=%b side=%b",
                 i, ok, value, main_lights, side_lights, ev[i], em[i], es[i]);
      end
    end
  endtask

  task automatic test_sensor_drop;
    logic       ok;
    logic [3:0] ev[5] = '{4'd2, 4'd6, 4'd2, 4'd6, 4'd3};
    logic [2:0] em[5] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    logic [2:0] es[5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    sensor = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_start(40, ok);
      tests++;
      if (!ok || value !== ev[i] || main_lights !== em[i] || side_lights !== es[i]) begin
        fails++;
        $display("FAIL drop[%0d]: ok=%b value=%0d main=%b side=%b, want value=%0d main=%b side=%b",
                 i, ok, value, main_lights, side_lights, ev[i], em[i], es[i]);
      end
      if (i == 1) sensor = 1'b0;  // drop during SG
    end
  endtask

`ifdef TRAFFIC_WALK_EN
  task automatic test_walk;
    logic       ok;
    logic [3:0] ev[8] = '{4'd2, 4'd5, 4'd6, 4'd3, 4'd2, 4'd6, 4'd2, 4'd5};
    logic [2:0] em[8] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] es[8] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    logic       ew[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    walk_req = 1'b1;
    @(negedge clk1);
    walk_req = 1'b0;
    sensor   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start(40, ok);
      tests++;
      if (!ok || value !== ev[i] || main_lights !== em[i] || side_lights !== es[i] ||
          walk_lamp !== ew[i]) begin
        fails++;
        $display("FAIL walk[%0d]: ok=%b value=%0d main=%b side=%b walk=%b, want %0d %b %b %b",
                 i, ok, value, main_lights, side_lights, walk_lamp, ev[i], em[i], es[i], ew[i]);
      end
      if (i == 1) begin
        // Request during WALK is kept for the next round.
        @(negedge clk1);
        walk_req = 1'b1;
        @(negedge clk1);
        walk_req = 1'b0;
      end
    end
  endtask
`else
  task automatic test_walk;
    logic       ok;
    logic [3:0] ev[2] = '{4'd2, 4'd6};
    logic [2:0] em[2] = '{3'b010, 3'b100};
    logic [2:0] es[2] = '{3'b100, 3'b001};
    walk_req = 1'b1;
    @(negedge clk1);
    walk_req = 1'b0;
    sensor   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_start(40, ok);
      tests++;
      if (!ok || value !== ev[i] || main_lights !== em[i] || side_lights !== es[i] ||
          walk_lamp !== 1'b0) begin
        fails++;
        $display("FAIL nowalk[%0d]: ok=%b value=%0d main=%b side=%b walk=%b, want %0d %b %b 0",
                 i, ok, value, main_lights, side_lights, walk_lamp, ev[i], em[i], es[i]);
      end
    end
  endtask
`endif

  task automatic test_expired_high;
    logic ok;
    int   gap;
    sensor = 1'b1;
    wait_start(40, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL exp_sync: no start seen, want a start pulse");
    end
    force_exp = 1'b1;
    wait_start(40, ok);  // interval already running is cut short; resync here
    for (int i = 0; i < 6; i++) begin
      gap = 0;
      ok  = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk1);
        gap++;
        if (start_timer) begin
          ok = 1'b1;
          break;
        end
      end
      tests++;
      if (!ok || gap != 3) begin
        fails++;
        $display("FAIL exp_gap[%0d]: ok=%b cycles=%0d, want 3", i, ok, gap);
      end
      tests++;
      if ((main_lights != 3'b100 && side_lights != 3'b100) ||
          (main_lights == side_lights && main_lights != 3'b100)) begin
        fails++;
        $display("FAIL exp_safe[%0d]: main=%b side=%b, want one side red", i, main_lights, side_lights);
      end
    end
    force_exp = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic found;
    sensor = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_start(40, ok);
      if (ok && side_lights == 3'b001 && value == 4'd6) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL find_sg: SG not reached, want SG entry");
    end
    repeat (2) @(negedge clk1);
    reset_n = 1'b0;
    #1;
    tests++;
    if (main_lights !== 3'b001 || side_lights !== 3'b100 || start_timer !== 1'b0 ||
        value !== 4'd6 || walk_lamp !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: main=%b side=%b start=%b value=%0d walk=%b, want 001 100 0 6 0",
               main_lights, side_lights, start_timer, value, walk_lamp);
    end
    @(negedge clk1);
    reset_n = 1'b1;
    @(negedge clk1);
    tests++;
    if (start_timer !== 1'b1 || value !== 4'd6 || main_lights !== 3'b001) begin
      fails++;
      $display("FAIL restart: start=%b value=%0d main=%b, want 1 6 001",
               start_timer, value, main_lights);
    end
    @(negedge clk1);
    tests++;
    if (start_timer !== 1'b0) begin
      fails++;
      $display("FAIL restart_width: start=%b, want 0", start_timer);
    end
  endtask

  initial begin
    test_reset;
    test_sensor_cycle;
    test_sensor_drop;
    test_walk;
    test_expired_high;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
